// File: rtl/ifu_pkg.sv
// Shared IFU definitions: instruction width, NOP encoding, default reset PC and FSM encoding.
package ifu_pkg;

  localparam int unsigned InstWidth = 32;
  localparam logic [InstWidth-1:0] InstNop = 32'h0000_0013;
  localparam logic [63:0] ResetPcDefault = 64'h0000_0000_8000_0000;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StReq  = 3'd1,
    StWait = 3'd2,
    StHold = 3'd3,
    StHalt = 3'd4
  } ifu_state_e;

endpackage

// File: rtl/ifu.sv
// Single-outstanding instruction fetch unit: REQ -> WAIT -> HOLD per instruction.
// Optional misaligned-redirect trap enabled by defining IFU_MISALIGN_CHECK_EN.
module ifu
  import ifu_pkg::*;
#(
  parameter int unsigned    PCW      = 64,
  parameter logic [PCW-1:0] RESET_PC = PCW'(ResetPcDefault)
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 imem_req_valid,
  input  logic                 imem_req_ready,
  output logic [PCW-1:0]       imem_req_addr,
  input  logic                 imem_rsp_valid,
  input  logic [InstWidth-1:0] imem_rsp_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [InstWidth-1:0] out_inst,
  output logic [PCW-1:0]       out_pc,
  input  logic                 redirect_valid,
  input  logic [PCW-1:0]       redirect_pc,
  input  logic                 halt,
  output logic                 fetch_fault
);

  ifu_state_e           state_q, state_d;
  logic [PCW-1:0]       pc_q, pc_d;
  logic [PCW-1:0]       req_addr_q, req_addr_d;
  logic                 drop_q, drop_d;
  logic                 halt_pend_q, halt_pend_d;
  logic                 out_valid_q, out_valid_d;
  logic [InstWidth-1:0] out_inst_q, out_inst_d;
  logic [PCW-1:0]       out_pc_q, out_pc_d;
  logic                 fault_q, fault_d;

  logic [PCW-1:0] redirect_tgt;
  logic [PCW-1:0] next_pc;
  logic           misalign;

`ifdef IFU_MISALIGN_CHECK_EN
  assign redirect_tgt = redirect_pc;
  assign misalign     = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
  // Low bits are silently forced to word alignment.
  assign redirect_tgt = redirect_pc & ~PCW'(3);
  assign misalign     = 1'b0;
`endif

  assign next_pc = redirect_valid ? redirect_tgt : pc_q + PCW'(4);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_addr_d  = req_addr_q;
    drop_d      = drop_q;
    halt_pend_d = halt_pend_q;
    out_valid_d = out_valid_q;
    out_inst_d  = out_inst_q;
    out_pc_d    = out_pc_q;
    fault_d     = fault_q;

    unique case (state_q)
      StIdle: begin
        req_addr_d = pc_q;
        if (halt) begin
          state_d = StHalt;
        end else if (misalign) begin
          fault_d = 1'b1;
          state_d = StHalt;
        end else begin
          // A redirect here behaves like one during an unaccepted request.
          if (redirect_valid) begin
            pc_d   = redirect_tgt;
            drop_d = 1'b1;
          end
          state_d = StReq;
        end
      end

      StReq: begin
        if (halt) begin
          state_d = StHalt;
        end else if (misalign) begin
          fault_d = 1'b1;
          state_d = StHalt;
        end else begin
          if (redirect_valid) begin
            pc_d   = redirect_tgt;
            drop_d = 1'b1;
          end
          if (imem_req_ready) state_d = StWait;
        end
      end

      StWait: begin
        if (halt || halt_pend_q) begin
          // Drain the outstanding response before parking.
          if (imem_rsp_valid) begin
            halt_pend_d = 1'b0;
            state_d     = StHalt;
          end else begin
            halt_pend_d = 1'b1;
          end
        end else if (misalign) begin
          fault_d = 1'b1;
          state_d = StHalt;
        end else if (redirect_valid) begin
          pc_d = redirect_tgt;
          if (imem_rsp_valid) begin
            req_addr_d = redirect_tgt;
            drop_d     = 1'b0;
            state_d    = StReq;
          end else begin
            drop_d = 1'b1;
          end
        end else if (imem_rsp_valid) begin
          if (drop_q) begin
            req_addr_d = pc_q;
            drop_d     = 1'b0;
            state_d    = StReq;
          end else begin
            out_inst_d  = imem_rsp_data;
            out_pc_d    = req_addr_q;
            out_valid_d = 1'b1;
            state_d     = StHold;
          end
        end
      end

      StHold: begin
        if (halt) begin
          out_valid_d = 1'b0;
          state_d     = StHalt;
        end else if (misalign) begin
          fault_d     = 1'b1;
          out_valid_d = 1'b0;
          state_d     = StHalt;
        end else if (out_ready || redirect_valid) begin
          out_valid_d = 1'b0;
          pc_d        = next_pc;
          req_addr_d  = next_pc;
          state_d     = StReq;
        end
      end

      StHalt: begin
        state_d = StHalt;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      pc_q        <= RESET_PC;
      req_addr_q  <= RESET_PC;
      drop_q      <= 1'b0;
      halt_pend_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_inst_q  <= InstNop;
      out_pc_q    <= RESET_PC;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_addr_q  <= req_addr_d;
      drop_q      <= drop_d;
      halt_pend_q <= halt_pend_d;
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      out_pc_q    <= out_pc_d;
      fault_q     <= fault_d;
    end
  end

  assign imem_req_valid = (state_q == StReq);
  assign imem_req_addr  = req_addr_q;
  assign out_valid      = out_valid_q;
  assign out_inst       = out_inst_q;
  assign out_pc         = out_pc_q;
  assign fetch_fault    = fault_q;

endmodule

// File: tb/tb_ifu.sv
// Scoreboard bench for ifu: a memory model checks request addresses, a monitor checks
// delivered instructions; directed sequences cover stall, redirect, halt and misalignment.
module tb_ifu;

  localparam logic [63:0] Base = 64'h0000_0000_8000_0000;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } out_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [63:0] out_pc;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        halt;
  logic        fetch_fault;

  int n_tests = 0;
  int n_fail  = 0;
  int mem_lat = 0;
  bit bad_next = 1'b0;

  logic [63:0] exp_req[$];
  out_t        exp_out[$];

  ifu dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_inst      (out_inst),
    .out_pc        (out_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .halt          (halt),
    .fetch_fault   (fetch_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_data(input logic [63:0] a);
    return a[31:0] ^ 32'h5a5a_0000;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic push_out(input logic [63:0] pc);
    out_t o;
    o.pc   = pc;
    o.inst = mem_data(pc);
    exp_out.push_back(o);
  endtask

  // Memory model: one response per accepted request, mem_lat extra cycles late.
  initial begin
    logic [63:0] a;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    forever begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) begin
        a = imem_req_addr;
        if (exp_req.size() == 0) timeout_fail("unexpected_request");
        else check("req_addr", a, exp_req.pop_front());
        @(posedge clk);
        repeat (mem_lat) @(posedge clk);
        #1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = bad_next ? 32'hdead_beef : mem_data(a);
        bad_next       = 1'b0;
        @(posedge clk);
        #1;
        imem_rsp_valid = 1'b0;
      end
    end
  end

  // Output monitor: every decoder handshake must match the next expected instruction.
  always @(negedge clk) begin
    out_t e;
    if (!rst && out_valid && out_ready) begin
      if (exp_out.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_output: got pc %h inst %h, expected none", out_pc, out_inst);
      end else begin
        e = exp_out.pop_front();
        check("out_pc", out_pc, e.pc);
        check("out_inst", {32'h0, out_inst}, {32'h0, e.inst});
      end
    end
  end

  task automatic wait_out_valid(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    if (!seen) timeout_fail(name);
  endtask

  task automatic wait_req_accept(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) seen = 1'b1;
    end
    if (!seen) timeout_fail(name);
    @(posedge clk);
    #1;
  endtask

  // Called at a negedge with out_valid high: one-cycle decoder handshake.
  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int n_hs;
    int guard;
    int n_req;
    int n_out;
    rst            = 1'b1;
    imem_req_ready = 1'b1;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 64'h0;
    halt           = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {63'h0, out_valid}, 64'h0);
    check("rst_req_valid", {63'h0, imem_req_valid}, 64'h0);
    check("rst_out_inst", {32'h0, out_inst}, 64'h13);
    check("rst_out_pc", out_pc, Base);
    check("rst_fault", {63'h0, fetch_fault}, 64'h0);

    // Streaming fetch with decoder always ready
    exp_req.push_back(Base);
    exp_req.push_back(Base + 64'h4);
    exp_req.push_back(Base + 64'h8);
    exp_req.push_back(Base + 64'hc);
    push_out(Base);
    push_out(Base + 64'h4);
    push_out(Base + 64'h8);
    @(posedge clk);
    #1 rst = 1'b0;
    n_hs  = 0;
    guard = 0;
    while (n_hs < 3 && guard < 100) begin
      @(negedge clk);
      guard++;
      if (out_valid && out_ready) n_hs++;
    end
    if (n_hs < 3) timeout_fail("stream_handshakes");
    @(posedge clk);
    #1 out_ready = 1'b0;

    // Decoder stall: output stable, no new request
    push_out(Base + 64'hc);
    wait_out_valid("stall_out_valid");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", {63'h0, out_valid}, 64'h1);
      check("stall_pc", out_pc, Base + 64'hc);
      check("stall_inst", {32'h0, out_inst}, {32'h0, mem_data(Base + 64'hc)});
      check("stall_no_req", {63'h0, imem_req_valid}, 64'h0);
    end
    exp_req.push_back(Base + 64'h10);
    mem_lat  = 3;
    bad_next = 1'b1;
    consume();

    // Redirect during WAIT: 0xdeadbeef response must be dropped
    exp_req.push_back(Base + 64'h100);
    push_out(Base + 64'h100);
    wait_req_accept("wait_redirect_accept");
    redirect_valid = 1'b1;
    redirect_pc    = Base + 64'h100;
    @(posedge clk);
    #1 redirect_valid = 1'b0;
    mem_lat = 0;
    wait_out_valid("wait_redirect_out");

    // Redirect coincident with handshake: redirect beats pc+4
    exp_req.push_back(Base + 64'h200);
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = Base + 64'h200;
    @(posedge clk);
    #1;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    @(negedge clk);
    check("hs_redirect_valid_drop", {63'h0, out_valid}, 64'h0);
    check("hs_redirect_addr", imem_req_addr, Base + 64'h200);

    // Halt during WAIT: response drained, fetch stops
    push_out(Base + 64'h200);
    wait_out_valid("halt_pre_out");
    exp_req.push_back(Base + 64'h204);
    mem_lat = 2;
    consume();
    wait_req_accept("halt_accept");
    halt = 1'b1;
    @(posedge clk);
    #1 halt = 1'b0;
    n_req = 0;
    n_out = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (imem_req_valid) n_req++;
      if (out_valid) n_out++;
    end
    check("halt_req_cycles", 64'(n_req), 64'h0);
    check("halt_out_cycles", 64'(n_out), 64'h0);
    mem_lat = 0;

    // Reset restarts from the reset PC
    exp_req.push_back(Base);
    push_out(Base);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    wait_out_valid("restart_out");
    exp_req.push_back(Base + 64'h4);
    consume();

    // Misaligned redirect while HOLD stalls (no handshake for 0x...04)
    wait_out_valid("misalign_pre_out");
`ifndef IFU_MISALIGN_CHECK_EN
    exp_req.push_back(Base + 64'h100);
`endif
    redirect_valid = 1'b1;
    redirect_pc    = Base + 64'h102;
    @(posedge clk);
    #1 redirect_valid = 1'b0;
    @(negedge clk);
    check("hold_redirect_valid_drop", {63'h0, out_valid}, 64'h0);
`ifdef IFU_MISALIGN_CHECK_EN
    check("misalign_fault", {63'h0, fetch_fault}, 64'h1);
    n_req = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (imem_req_valid) n_req++;
    end
    check("misalign_halt_no_req", 64'(n_req), 64'h0);
`else
    check("misalign_no_fault", {63'h0, fetch_fault}, 64'h0);
    push_out(Base + 64'h100);
    wait_out_valid("misalign_out");
    exp_req.push_back(Base + 64'h104);
    consume();
    repeat (4) @(negedge clk);
`endif

    check("exp_req_drained", 64'(exp_req.size()), 64'h0);
    check("exp_out_drained", 64'(exp_out.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
